note_player: RTL and testbench
==============================

NOTE_PLAYER -- requirements
Module: note_player

Interface
REQ-001 clk  input  1  system clock (50 MHz); all state changes on its rising edge.
REQ-002 resetn  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  single-cycle play request; ignored unless FSM is IDLE.
REQ-004 stop  input  1  single-cycle abort; honoured in every state.
REQ-005 beat  input  1  one-cycle tempo tick from the shared clock divider.
REQ-006 rec_len  input  6  number of recorded notes; 0 means empty; sampled on accepted start.
REQ-007 rd_en  output  1  note RAM read enable.
REQ-008 rd_addr  output  6  note RAM read address.
REQ-009 rd_data  input  32  note word returned by the RAM one clock after rd_en.
REQ-010 string_on  output  6  bit s is high while string s sounds.
REQ-011 fret  output  18  3-bit fret code per string; string s occupies bits [3s+2:3s]; 0 = open, 1..4 = bar.
REQ-012 note_valid  output  1  one-cycle pulse when string_on and fret update.
REQ-013 busy  output  1  high in every state except IDLE and DONE.
REQ-014 done  output  1  one-cycle pulse when playback ends without stop.
REQ-015 decode_err  output  1  one-cycle pulse alongside note_valid for a malformed word.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT_BEAT, FETCH, LATCH and DONE.
REQ-017 IDLE -> WAIT_BEAT on start; the address SHALL clear to 0 and rec_len SHALL be latched; if rec_len=0, go IDLE -> DONE instead.
REQ-018 WAIT_BEAT -> FETCH on beat.
REQ-019 FETCH SHALL drive rd_en=1 and rd_addr=address for exactly one cycle, then go to LATCH.
REQ-020 On the edge leaving LATCH, the block SHALL register the decoded rd_data, pulse note_valid and increment the address.
REQ-021 Latency: outputs SHALL update on the second rising edge after the edge that samples beat.
REQ-022 Beats arriving in FETCH or LATCH SHALL be ignored, not queued.
REQ-023 Decode: word bit 6f+s set SHALL mean string s at fret f (f=0..4); the block SHALL set string_on[s] if any such bit is set.
REQ-024 When one string has several fret bits set, the highest fret SHALL win and decode_err SHALL pulse.
REQ-025 Nonzero bits [31:30] SHALL pulse decode_err, and those bits SHALL otherwise be ignored.
REQ-026 After the note at address latched_len-1, LATCH SHALL go to DONE, not WAIT_BEAT.
REQ-027 On entering DONE, the block SHALL pulse done, keep the last note on string_on/fret, and return to IDLE the next cycle.
REQ-028 stop in any state SHALL force IDLE next edge and clear string_on and fret; no done pulse.
REQ-029 If stop and start are both high in IDLE, stop SHALL win and the block SHALL remain idle.
REQ-030 Address arithmetic SHALL be 6-bit modulo 64; rec_len=63 plays addresses 0..62.

Reset
REQ-031 While resetn=0, the FSM SHALL be IDLE, the address and latched length SHALL be 0, and all outputs SHALL be 0 immediately, independent of clk.
REQ-032 Reset asserted mid-FETCH SHALL discard the pending read; the next rd_data SHALL be ignored.

Configuration
REQ-033 With PLAY_LOOP_EN defined, REQ-026 SHALL become: after address latched_len-1, wrap to 0 and go to WAIT_BEAT; done SHALL never pulse; only stop ends play.
REQ-034 Without PLAY_LOOP_EN, the block SHALL follow REQ-026/027 exactly, with no loop logic present.

Structure
REQ-035 Shared package: NUM_STRINGS=6, NUM_FRETS=5, ADDR_W=6, NOTE_W=32, FRET_W=3, FSM state enum.
REQ-036 Decoding SHALL sit in a combinational sub-module note_decoder, the inverse of the recorder's coordinate converter.

Verification
REQ-037 rec_len=3, RAM {0x1, 0x80, 0x20000000}, start, 3 beats -> string_on 000001/000010/100000, fret[2:0]=0, fret[5:3]=1, fret[17:15]=4; done one cycle after third note_valid.
REQ-038 beat at edge N -> rd_en high cycle N..N+1, note_valid at edge N+2; second beat at N+1 -> no extra read.
REQ-039 word 0x00001041 (string 0 at frets 0, 2; plus bit 6) -> string_on[0]=1, fret[2:0]=2, decode_err pulse.
REQ-040 rec_len=0, start -> done pulse next cycle, rd_en never asserted.
REQ-041 stop after second of 4 notes -> string_on=0 next cycle, no done, busy low; resetn low mid-FETCH -> outputs 0 asynchronously.
REQ-042 PLAY_LOOP_EN, rec_len=2, 5 beats -> rd_addr sequence 0,1,0,1,0; done never pulses.

Source files
------------

// File: rtl/note_player_pkg.sv
// note_player_pkg: shared sizes and FSM state encoding for the note player.
//   NUM_STRINGS / NUM_FRETS  guitar geometry (6 strings, frets 0..4)
//   ADDR_W                   note RAM address width
//   NOTE_W                   note word width
//   FRET_W                   per-string fret code width
`timescale 1ns / 1ps
package note_player_pkg;

  localparam int unsigned NUM_STRINGS = 6;
  localparam int unsigned NUM_FRETS   = 5;
  localparam int unsigned ADDR_W      = 6;
  localparam int unsigned NOTE_W      = 32;
  localparam int unsigned FRET_W      = 3;

  typedef enum logic [2:0] {
    StIdle,
    StWaitBeat,
    StFetch,
    StLatch,
    StDone
  } state_e;

endpackage

// File: rtl/note_player_decoder.sv
// note_decoder: combinational decode of one recorded note word.
// Bit (NUM_STRINGS*f + s) set means string s is played at fret f.
//   word_i       note word from RAM
//   string_on_o  one bit per sounding string
//   fret_o       FRET_W-bit fret code per string (highest fret wins)
//   err_o        several frets on one string, or unused top bits set
`timescale 1ns / 1ps
module note_decoder
  import note_player_pkg::*;
(
  input  logic [NOTE_W-1:0]             word_i,
  output logic [NUM_STRINGS-1:0]        string_on_o,
  output logic [NUM_STRINGS*FRET_W-1:0] fret_o,
  output logic                          err_o
);

  logic [NUM_STRINGS-1:0]        son;
  logic [NUM_STRINGS*FRET_W-1:0] fr;
  logic                          err;

  always_comb begin
    son = '0;
    fr  = '0;
    err = |word_i[NOTE_W-1:NUM_STRINGS*NUM_FRETS];
    for (int s = 0; s < NUM_STRINGS; s++) begin
      // Ascending fret scan: a later hit overrides, and a second hit is malformed.
      for (int f = 0; f < NUM_FRETS; f++) begin
        if (word_i[f*NUM_STRINGS+s]) begin
          if (son[s]) err = 1'b1;
          son[s]                 = 1'b1;
          fr[s*FRET_W +: FRET_W] = FRET_W'(f);
        end
      end
    end
  end

  assign string_on_o = son;
  assign fret_o      = fr;
  assign err_o       = err;

endmodule

// File: rtl/note_player.sv
// note_player: plays back recorded notes from the note RAM, one per tempo beat.
//   clk_i, resetn_i        clock, async active-low reset
//   start_i, stop_i        play request (IDLE only) / abort (any state)
//   beat_i                 tempo tick
//   rec_len_i              number of recorded notes, sampled on accepted start
//   rd_en_o, rd_addr_o     note RAM read port; rd_data_i valid one clock later
//   string_on_o, fret_o    current note
//   note_valid_o           pulse when the note outputs update
//   decode_err_o           pulse with note_valid_o for a malformed word
//   busy_o, done_o         activity / normal end-of-playback pulse
// Build option: define PLAY_LOOP_EN to loop playback forever until stop.
`timescale 1ns / 1ps
module note_player
  import note_player_pkg::*;
(
  input  logic                          clk_i,
  input  logic                          resetn_i,
  input  logic                          start_i,
  input  logic                          stop_i,
  input  logic                          beat_i,
  input  logic [ADDR_W-1:0]             rec_len_i,
  output logic                          rd_en_o,
  output logic [ADDR_W-1:0]             rd_addr_o,
  input  logic [NOTE_W-1:0]             rd_data_i,
  output logic [NUM_STRINGS-1:0]        string_on_o,
  output logic [NUM_STRINGS*FRET_W-1:0] fret_o,
  output logic                          note_valid_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          decode_err_o
);

  state_e                        state_q, state_d;
  logic [ADDR_W-1:0]             addr_q, addr_d;
  logic [ADDR_W-1:0]             len_q, len_d;
  logic [NUM_STRINGS-1:0]        son_q, son_d;
  logic [NUM_STRINGS*FRET_W-1:0] fret_q, fret_d;
  logic                          nv_q, nv_d;
  logic                          err_q, err_d;

  logic [NUM_STRINGS-1:0]        dec_son;
  logic [NUM_STRINGS*FRET_W-1:0] dec_fret;
  logic                          dec_err;

  note_decoder u_decoder (
    .word_i      (rd_data_i),
    .string_on_o (dec_son),
    .fret_o      (dec_fret),
    .err_o       (dec_err)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    son_d   = son_q;
    fret_d  = fret_q;
    nv_d    = 1'b0;
    err_d   = 1'b0;
    if (stop_i) begin
      state_d = StIdle;
      son_d   = '0;
      fret_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            addr_d = '0;
            len_d  = rec_len_i;
`ifdef PLAY_LOOP_EN
            // Looping play never signals done, so an empty recording just stays idle.
            state_d = (rec_len_i == '0) ? StIdle : StWaitBeat;
`else
            state_d = (rec_len_i == '0) ? StDone : StWaitBeat;
`endif
          end
        end
        StWaitBeat: if (beat_i) state_d = StFetch;
        StFetch:    state_d = StLatch;
        StLatch: begin
          son_d   = dec_son;
          fret_d  = dec_fret;
          nv_d    = 1'b1;
          err_d   = dec_err;
          addr_d  = addr_q + ADDR_W'(1);
          state_d = StWaitBeat;
          if (addr_q == len_q - ADDR_W'(1)) begin
`ifdef PLAY_LOOP_EN
            addr_d = '0;
`else
            state_d = StDone;
`endif
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      len_q   <= '0;
      son_q   <= '0;
      fret_q  <= '0;
      nv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      son_q   <= son_d;
      fret_q  <= fret_d;
      nv_q    <= nv_d;
      err_q   <= err_d;
    end
  end

  // State-decoded outputs fall to zero the moment reset forces IDLE.
  assign rd_en_o      = (state_q == StFetch);
  assign rd_addr_o    = rd_en_o ? addr_q : '0;
  assign busy_o       = (state_q != StIdle) && (state_q != StDone);
  assign done_o       = (state_q == StDone);
  assign string_on_o  = son_q;
  assign fret_o       = fret_q;
  assign note_valid_o = nv_q;
  assign decode_err_o = err_q;

endmodule

// File: tb/tb_note_player.sv
`timescale 1ns / 1ps
module tb_note_player;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        beat = 1'b0;
  logic [5:0]  rec_len = '0;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data = '0;
  logic [5:0]  string_on;
  logic [17:0] fret;
  logic        note_valid, busy, done, decode_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [64];

  note_player dut (
    .clk_i        (clk),
    .resetn_i     (resetn),
    .start_i      (start),
    .stop_i       (stop),
    .beat_i       (beat),
    .rec_len_i    (rec_len),
    .rd_en_o      (rd_en),
    .rd_addr_o    (rd_addr),
    .rd_data_i    (rd_data),
    .string_on_o  (string_on),
    .fret_o       (fret),
    .note_valid_o (note_valid),
    .busy_o       (busy),
    .done_o       (done),
    .decode_err_o (decode_err)
  );

  always #10 clk = ~clk;

  // Synchronous RAM; garbage when not read so stale data would be caught.
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : $urandom;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: walk every set bit; bit i names string i%6 at fret i/6.
  function automatic logic [24:0] ref_decode(input logic [31:0] w);
    logic [5:0]  son;
    logic [17:0] fr;
    logic        err;
    int          hi [6];
    son = '0;
    fr  = '0;
    err = (w[31:30] != 2'b00);
    for (int s = 0; s < 6; s++) hi[s] = 0;
    for (int i = 0; i < 30; i++) begin
      if (w[i]) begin
        if (son[i % 6]) err = 1'b1;
        son[i % 6] = 1'b1;
        if (i / 6 > hi[i % 6]) hi[i % 6] = i / 6;
      end
    end
    for (int s = 0; s < 6; s++) fr = fr | (18'(hi[s]) << (3 * s));
    return {err, fr, son};
  endfunction

  function automatic logic [34:0] all_outs();
    return {rd_en, rd_addr, string_on, fret, note_valid, busy, done, decode_err};
  endfunction

  task automatic start_play(input logic [5:0] len);
    start   = 1'b1;
    rec_len = len;
    tick();
    start   = 1'b0;
    rec_len = 6'($urandom);
    if (len == 0) begin
`ifdef PLAY_LOOP_EN
      chk("empty_no_done", {done, busy}, 2'b00);
`else
      chk("empty_done", {done, busy}, 2'b10);
`endif
      chk("empty_no_read", rd_en, 0);
      tick();
      chk("empty_done_end", {done, rd_en}, 2'b00);
    end else begin
      chk("start_busy", {busy, done}, 2'b10);
    end
  endtask

  // One note: beat sampled at edge N, read during N..N+1, outputs at N+2.
  task automatic play_note(input int addr, input int len, input int gap);
    logic [24:0] r;
    bit          last;
    last = (addr == len - 1);
    repeat (gap) tick();
    chk("wait_no_read", rd_en, 0);
    beat = 1'b1;
    tick();
    beat = 1'($urandom);  // second beat while fetching must be ignored
    chk("fetch_rd_en", rd_en, 1);
    chk("fetch_rd_addr", rd_addr, 64'(addr));
    tick();
    beat = 1'b0;
    chk("latch_quiet", {rd_en, note_valid}, 2'b00);
    tick();
    r = ref_decode(mem[addr]);
    chk("note_valid", note_valid, 1);
    chk("string_on", string_on, 64'(r[5:0]));
    chk("fret", fret, 64'(r[23:6]));
    chk("decode_err", decode_err, 64'(r[24]));
`ifdef PLAY_LOOP_EN
    chk("loop_no_done", {done, busy}, 2'b01);
`else
    chk("done_busy", {done, busy}, last ? 2'b10 : 2'b01);
`endif
    tick();
    chk("after_note", {note_valid, rd_en, done, decode_err}, 4'b0000);
  endtask

  task automatic end_play();
`ifdef PLAY_LOOP_EN
    stop = 1'b1;
    tick();
    stop = 1'b0;
`endif
    tick();
  endtask

  task automatic play_seq(input int len, input int max_gap);
    start_play(6'(len));
    for (int i = 0; i < len; i++) play_note(i, len, $urandom_range(0, max_gap));
    end_play();
  endtask

  initial begin
    // Reset: outputs zero regardless of clock
    #5;
    chk("reset_outs", 64'(all_outs()), 0);
    tick();
    tick();
    chk("reset_outs_clk", 64'(all_outs()), 0);
    resetn = 1'b1;
    tick();
    chk("idle_outs", 64'(all_outs()), 0);

    // Directed three-note example
    mem[0] = 32'h1;
    mem[1] = 32'h80;
    mem[2] = 32'h2000_0000;
    play_seq(3, 1);

    // Malformed word: string 0 at frets 0,1,2
    mem[0] = 32'h0000_1041;
    play_seq(1, 0);

    // Empty recording
    start_play(6'd0);
    tick();

    // Random recordings
    for (int t = 0; t < 8; t++) begin
      int len;
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++)
        mem[i] = ($urandom_range(0, 1) == 0) ? (32'h1 << $urandom_range(0, 29)) : $urandom;
      play_seq(len, 3);
    end

    // Full-length recording: addresses 0..62
    for (int i = 0; i < 64; i++) mem[i] = 32'h1 << (i % 30);
    play_seq(63, 0);

`ifdef PLAY_LOOP_EN
    // Looping: 2 notes, 5 beats -> addresses 0,1,0,1,0
    mem[0] = 32'h2;
    mem[1] = 32'h100;
    start_play(6'd2);
    for (int i = 0; i < 5; i++) play_note(i % 2, 2, 1);
    end_play();
`endif

    // Stop after the second of four notes
    mem[0] = 32'h4;
    mem[1] = 32'h0004_0000;
    mem[2] = 32'h8;
    mem[3] = 32'h10;
    start_play(6'd4);
    play_note(0, 4, 0);
    play_note(1, 4, 1);
    chk("pre_stop_note", string_on, 64'(6'b000001));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_clear", {string_on, fret}, 0);
    chk("stop_idle", {busy, done, note_valid}, 3'b000);
    for (int i = 0; i < 4; i++) begin
      beat = 1'b1;
      tick();
      chk("stopped_quiet", {rd_en, done, busy}, 3'b000);
    end
    beat = 1'b0;

    // Stop beats start in IDLE
    start   = 1'b1;
    stop    = 1'b1;
    rec_len = 6'd5;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("stop_wins", {busy, done}, 2'b00);
    beat = 1'b1;
    tick();
    beat = 1'b0;
    tick();
    chk("stop_wins_no_read", {rd_en, busy}, 2'b00);

    // Reset while fetching: outputs drop asynchronously, read is discarded
    mem[0] = 32'h3f;
    mem[1] = 32'h3f;
    start_play(6'd2);
    play_note(0, 2, 0);
    beat = 1'b1;
    tick();
    beat = 1'b0;
    chk("in_fetch", rd_en, 1);
    #3;
    resetn = 1'b0;
    #1;
    chk("async_reset_outs", 64'(all_outs()), 0);
    tick();
    resetn = 1'b1;
    tick();
    chk("post_reset_quiet", 64'(all_outs()), 0);
    tick();
    chk("post_reset_no_note", {note_valid, busy, rd_en}, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so a stuck run still reports.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
